// File: rtl/uart_rx_8n1_os_pkg.sv
// Shared UART definitions: FSM state encoding, default line parameters,
// tick divider expression and the 2-of-3 vote helper.
package uart_rx_8n1_os_pkg;

  typedef enum logic [2:0] {
    WAIT_HIGH = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } rx_state_t;

  localparam int DEF_CLK_HZ     = 12000000;
  localparam int DEF_BAUD       = 9600;
  localparam int DEF_OVERSAMPLE = 16;

  // Truncating divide: 78 at the defaults (0.16% fast)
  function automatic int tick_div(input int clk_hz, input int baud, input int os);
    return clk_hz / (baud * os);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_8n1_os_if.sv
// Byte delivery channel of the UART receiver: data plus valid/ready handshake.
// The receiver drives through master, the consumer through slave.
interface uart_rx_8n1_os_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_8n1_os_baud_tick.sv
// Free-running divider: one-clk tick every DIV clocks, restarted only by rst.
// Shared between the UART receive and transmit sides.
module uart_baud_tick #(
  parameter int DIV = 78
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_8n1_os.sv
// UART 8N1 receiver, oversampled with a 2-of-3 mid-bit vote per bit.
// Bytes land in a one-entry holding register drained by valid/ready.
module uart_rx_8n1_os
  import uart_rx_8n1_os_pkg::*;
#(
  parameter int CLK_HZ     = DEF_CLK_HZ,
  parameter int BAUD       = DEF_BAUD,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_in,
  uart_rx_8n1_os_if.master  rx,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int TICK_DIV = tick_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int MID      = OVERSAMPLE / 2;
  localparam int OSW      = $clog2(OVERSAMPLE);
  localparam logic [OSW-1:0] OS_V0   = OSW'(MID - 1);
  localparam logic [OSW-1:0] OS_V1   = OSW'(MID);
  localparam logic [OSW-1:0] OS_V2   = OSW'(MID + 1);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);

  rx_state_t      state, state_nxt;
  logic           tick;
  logic           rx_meta, rx_s;
  logic [OSW-1:0] os_cnt;
  logic [2:0]     bit_cnt;
  logic           samp_a, samp_b;
  logic [7:0]     shreg;
  logic           stop_done, stop_bit;
  logic           vote, vote_now, os_wrap;
  logic           os_clr, shift_en, bit_inc, stop_set, deliver, ferr_now;

  uart_baud_tick #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  assign vote     = maj3(samp_a, samp_b, rx_s);
  assign vote_now = tick && (os_cnt == OS_V2);
  assign os_wrap  = tick && (os_cnt == OS_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WAIT_HIGH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    os_clr    = 1'b0;
    shift_en  = 1'b0;
    bit_inc   = 1'b0;
    stop_set  = 1'b0;
    deliver   = 1'b0;
    ferr_now  = 1'b0;
    case (state)
      // Synchroniser flops come out of reset high; waiting for a tick lets a
      // held-low line reach rx_s before it can be mistaken for idle.
      WAIT_HIGH: if (tick && rx_s) state_nxt = IDLE;
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          os_clr    = 1'b1;
        end
      end
      // A confirmed start bit runs to its end so DATA samples land mid-bit.
      START: begin
        if (vote_now && vote) begin
          state_nxt = IDLE;
        end else if (os_wrap) begin
          state_nxt = DATA;
          os_clr    = 1'b1;
        end
      end
      DATA: begin
        shift_en = vote_now;
        if (os_wrap) begin
          if (bit_cnt == 3'd7) begin
            state_nxt = STOP;
            os_clr    = 1'b1;
          end else begin
            bit_inc = 1'b1;
          end
        end
      end
      STOP: begin
        if (stop_done) begin
          if (stop_bit) begin
            state_nxt = IDLE;
            deliver   = 1'b1;
          end else begin
            state_nxt = WAIT_HIGH;
            ferr_now  = 1'b1;
          end
        end else begin
          stop_set = vote_now;
        end
      end
      default: state_nxt = WAIT_HIGH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      os_cnt    <= '0;
      bit_cnt   <= '0;
      samp_a    <= 1'b1;
      samp_b    <= 1'b1;
      shreg     <= '0;
      stop_done <= 1'b0;
      stop_bit  <= 1'b0;
    end else begin
      if (os_clr) begin
        os_cnt <= '0;
      end else if (tick) begin
        os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OSW'(1);
      end
      if (os_clr) begin
        bit_cnt <= '0;
      end else if (bit_inc) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (tick && (os_cnt == OS_V0)) samp_a <= rx_s;
      if (tick && (os_cnt == OS_V1)) samp_b <= rx_s;
      if (shift_en) shreg <= {vote, shreg[7:1]};
      if (stop_set) stop_bit <= vote;
      stop_done <= (state == STOP) && (state_nxt == STOP) && (stop_done || stop_set);
    end
  end

  // A transfer in the delivery cycle frees the slot for the new byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx.rx_data  <= 8'h00;
      rx.rx_valid <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (deliver && (!rx.rx_valid || rx.rx_ready)) begin
        rx.rx_data  <= shreg;
        rx.rx_valid <= 1'b1;
      end else if (rx.rx_valid && rx.rx_ready) begin
        rx.rx_valid <= 1'b0;
      end
      overrun   <= deliver && rx.rx_valid && !rx.rx_ready;
      frame_err <= ferr_now;
    end
  end

  assign busy = (state != IDLE) && (state != WAIT_HIGH);

endmodule
